// File: rtl/mslope_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the multi-slope conversion sequencer.
package mslope_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNUP   = 2'd1,
        RUNDOWN = 2'd2,
        ZEROS   = 2'd3
    } state_t;

    localparam int DEF_CYC_PER_PLC = 20;
    localparam int DEF_NPL_W       = 10;
    localparam int DEF_ZERO_CYC    = 5;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RD_TIMEOUT  = 255;

    // Counter width for a modulus n; a modulus of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mslope_sat_cnt.sv
`timescale 1ns/1ps
// Clear/increment counter that sticks at all-ones; clear with inc set loads 1
// so the first tick of a phase is counted on the same edge that clears.
module mslope_sat_cnt
    import mslope_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk1ms,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk1ms or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(W-1){1'b0}}, inc};
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mslope_seq.sv
`timescale 1ns/1ps
// Multi-slope sequencer: run-up, run-down, auto-zero; COMP_SYNC_EN adds a 2-flop comp synchroniser.
// All outputs registered one tick after the deciding edge; free-running, no backpressure.
module mslope_seq
    import mslope_pkg::*;
#(
    parameter int CYC_PER_PLC = DEF_CYC_PER_PLC,
    parameter int NPL_W       = DEF_NPL_W,
    parameter int ZERO_CYC    = DEF_ZERO_CYC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RD_TIMEOUT  = DEF_RD_TIMEOUT
) (
    input  logic             clk1ms,
    input  logic             rst,
    input  logic             enable,
    input  logic [NPL_W-1:0] npl,
    input  logic             comp,
    output logic             start,
    output logic             runup,
    output logic             rundown,
    output logic             ref_pos,
    output logic             ref_neg,
    output logic             zero,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] pos_cnt,
    output logic [CNT_W-1:0] neg_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int TICK_W = cnt_w(CYC_PER_PLC);
    localparam int ZC_W   = cnt_w(ZERO_CYC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYC_PER_PLC - 1);
    localparam logic [ZC_W-1:0]   ZC_LAST   = ZC_W'(ZERO_CYC - 1);
    localparam logic [CNT_W-1:0]  RD_LIMIT  = CNT_W'(RD_TIMEOUT);

    logic comp_s;

`ifdef COMP_SYNC_EN
    logic [1:0] comp_sync;

    always_ff @(posedge clk1ms or negedge rst) begin
        if (!rst) begin
            comp_sync <= '0;
        end else begin
            comp_sync <= {comp_sync[0], comp};
        end
    end

    assign comp_s = comp_sync[1];
`else
    assign comp_s = comp;
`endif

    state_t            state_q, state_nx;
    logic [NPL_W-1:0]  npl_q, npl_nx;
    logic [NPL_W-1:0]  plc_q, plc_nx;
    logic [TICK_W-1:0] tick_q, tick_nx;
    logic [ZC_W-1:0]   zc_q, zc_nx;
    logic              pol_q, pol_nx;
    logic              start_nx, runup_nx, rundown_nx, zero_nx, done_nx, timeout_nx;
    logic              ref_pos_nx, ref_neg_nx;
    logic              cnt_clr, pos_inc, neg_inc, rd_inc;

    always_comb begin
        state_nx   = state_q;
        npl_nx     = npl_q;
        plc_nx     = plc_q;
        tick_nx    = tick_q;
        zc_nx      = zc_q;
        timeout_nx = timeout;
        start_nx   = 1'b0;
        done_nx    = 1'b0;
        cnt_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    npl_nx     = npl;
                    plc_nx     = '0;
                    tick_nx    = '0;
                    cnt_clr    = 1'b1;
                    timeout_nx = 1'b0;
                    start_nx   = 1'b1;
                    state_nx   = (npl == '0) ? RUNDOWN : RUNUP;
                end
            end
            RUNUP: begin
                // Tick-within-PLC and PLC counters give npl_q*CYC_PER_PLC ticks without a multiplier.
                if (tick_q == TICK_LAST) begin
                    tick_nx = '0;
                    if (plc_q == npl_q - 1'b1) begin
                        state_nx = RUNDOWN;
                    end else begin
                        plc_nx = plc_q + 1'b1;
                    end
                end else begin
                    tick_nx = tick_q + 1'b1;
                end
            end
            RUNDOWN: begin
                if (comp_s != pol_q) begin
                    state_nx = ZEROS;
                    zc_nx    = '0;
                end else if (rd_cnt >= RD_LIMIT) begin
                    state_nx   = ZEROS;
                    zc_nx      = '0;
                    timeout_nx = 1'b1;
                end
            end
            ZEROS: begin
                if (zc_q == ZC_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    zc_nx = zc_q + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Polarity is frozen from the comparator value seen on run-down entry.
        pol_nx = (state_q == RUNDOWN) ? pol_q : comp_s;

        runup_nx   = (state_nx == RUNUP);
        rundown_nx = (state_nx == RUNDOWN);
        zero_nx    = (state_nx == ZEROS);

        ref_pos_nx = 1'b0;
        ref_neg_nx = 1'b0;
        if (runup_nx) begin
            ref_neg_nx = comp_s;
            ref_pos_nx = ~comp_s;
        end else if (rundown_nx) begin
            ref_neg_nx = pol_nx;
            ref_pos_nx = ~pol_nx;
        end

        pos_inc = runup_nx & ~comp_s;
        neg_inc = runup_nx & comp_s;
        rd_inc  = rundown_nx;
    end

    always_ff @(posedge clk1ms or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            npl_q   <= '0;
            plc_q   <= '0;
            tick_q  <= '0;
            zc_q    <= '0;
            pol_q   <= 1'b0;
            start   <= 1'b0;
            runup   <= 1'b0;
            rundown <= 1'b0;
            ref_pos <= 1'b0;
            ref_neg <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_nx;
            npl_q   <= npl_nx;
            plc_q   <= plc_nx;
            tick_q  <= tick_nx;
            zc_q    <= zc_nx;
            pol_q   <= pol_nx;
            start   <= start_nx;
            runup   <= runup_nx;
            rundown <= rundown_nx;
            ref_pos <= ref_pos_nx;
            ref_neg <= ref_neg_nx;
            zero    <= zero_nx;
            done    <= done_nx;
            timeout <= timeout_nx;
        end
    end

    mslope_sat_cnt #(.W(CNT_W)) u_pos_cnt (
        .clk1ms (clk1ms),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (pos_inc),
        .cnt    (pos_cnt)
    );

    mslope_sat_cnt #(.W(CNT_W)) u_neg_cnt (
        .clk1ms (clk1ms),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (neg_inc),
        .cnt    (neg_cnt)
    );

    mslope_sat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clk1ms (clk1ms),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (rd_inc),
        .cnt    (rd_cnt)
    );

endmodule
